mem_port_arbiter: RTL and testbench

//  Shares one single-port 64-bit memory between instruction fetch (I) and data

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 64-bit memory between instruction fetch (I) and
//   data access (D). Only one access is outstanding at a time. D has priority,
//   and a starvation counter makes sure a waiting I request eventually wins.
//   Access sequence: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
//
// Ports
//   Clk, Reset                 clock (rising edge), async active-low reset
//   IReq/IAddr                 fetch request and byte address (held until IGnt)
//   IGnt/IValid/IRdata         fetch grant pulse, completion pulse, read data
//   DReq/DWr/DAddr/DWdata      data request, write flag, address, write data
//   DGnt/DValid/DRdata         data grant pulse, completion pulse, read data
//   MemEn/MemWr                memory strobe and write enable (ISSUE cycle only)
//   MemAddr/MemWdata           captured address/write data to memory
//   MemRdata                   memory read data, valid MEM_LAT cycles after MemEn
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [63:0] IAddr,
  output logic        IGnt,
  output logic        IValid,
  output logic [63:0] IRdata,
  input  logic        DReq,
  input  logic        DWr,
  input  logic [63:0] DAddr,
  input  logic [63:0] DWdata,
  output logic        DGnt,
  output logic        DValid,
  output logic [63:0] DRdata,
  output logic        MemEn,
  output logic        MemWr,
  output logic [63:0] MemAddr,
  output logic [63:0] MemWdata,
  input  logic [63:0] MemRdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] LAST_WAIT  = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        owner_d_q;   // 1 = current access belongs to D
  logic        wr_q;
  logic [3:0]  wait_q;
  logic [3:0]  starve_q;

  logic        igrant_q, dgrant_q, ivalid_q, dvalid_q;
  logic        memen_q, memwr_q;
  logic [63:0] memaddr_q, memwdata_q, irdata_q, drdata_q;

  logic        d_win_d;

  // D wins unless I is pending and has already lost STARVE_MAX times in a row.
  always_comb begin
    d_win_d = DReq && (!IReq || (starve_q < STARVE_LIM));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      owner_d_q  <= 1'b0;
      wr_q       <= 1'b0;
      wait_q     <= '0;
      starve_q   <= '0;
      igrant_q   <= 1'b0;
      dgrant_q   <= 1'b0;
      ivalid_q   <= 1'b0;
      dvalid_q   <= 1'b0;
      memen_q    <= 1'b0;
      memwr_q    <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      // Strobes are single-cycle pulses; the state machine raises them only
      // on the edge entering ISSUE or RESP.
      igrant_q <= 1'b0;
      dgrant_q <= 1'b0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      memen_q  <= 1'b0;
      memwr_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (d_win_d) begin
            owner_d_q  <= 1'b1;
            wr_q       <= DWr;
            memaddr_q  <= DAddr;
            memwdata_q <= DWdata;
            dgrant_q   <= 1'b1;
            memen_q    <= 1'b1;
            memwr_q    <= DWr;
            // d_win_d with IReq implies starve_q < STARVE_LIM, so no overflow.
            if (IReq) starve_q <= starve_q + 4'd1;
            state_q    <= S_ISSUE;
          end else if (IReq) begin
            owner_d_q  <= 1'b0;
            wr_q       <= 1'b0;
            memaddr_q  <= IAddr;
            memwdata_q <= '0;
            igrant_q   <= 1'b1;
            memen_q    <= 1'b1;
            starve_q   <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == LAST_WAIT) begin
            if (!wr_q) begin
              if (owner_d_q) drdata_q <= MemRdata;
              else           irdata_q <= MemRdata;
            end
            dvalid_q <= owner_d_q;
            ivalid_q <= !owner_d_q;
            state_q  <= S_RESP;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign IGnt     = igrant_q;
  assign DGnt     = dgrant_q;
  assign IValid   = ivalid_q;
  assign DValid   = dvalid_q;
  assign MemEn    = memen_q;
  assign MemWr    = memwr_q;
  assign MemAddr  = memaddr_q;
  assign MemWdata = memwdata_q;
  assign IRdata   = irdata_q;
  assign DRdata   = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic Clk;
  logic Reset;

  // DUT A: MEM_LAT=1, STARVE_MAX=4
  logic        a_IReq, a_DReq, a_DWr;
  logic [63:0] a_IAddr, a_DAddr, a_DWdata, a_MemRdata;
  logic        a_IGnt, a_IValid, a_DGnt, a_DValid, a_MemEn, a_MemWr;
  logic [63:0] a_IRdata, a_DRdata, a_MemAddr, a_MemWdata;

  // DUT B: MEM_LAT=3
  logic        b_IReq, b_DReq, b_DWr;
  logic [63:0] b_IAddr, b_DAddr, b_DWdata, b_MemRdata;
  logic        b_IGnt, b_IValid, b_DGnt, b_DValid, b_MemEn, b_MemWr;
  logic [63:0] b_IRdata, b_DRdata, b_MemAddr, b_MemWdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .IReq(a_IReq), .IAddr(a_IAddr), .IGnt(a_IGnt), .IValid(a_IValid), .IRdata(a_IRdata),
    .DReq(a_DReq), .DWr(a_DWr), .DAddr(a_DAddr), .DWdata(a_DWdata),
    .DGnt(a_DGnt), .DValid(a_DValid), .DRdata(a_DRdata),
    .MemEn(a_MemEn), .MemWr(a_MemWr), .MemAddr(a_MemAddr), .MemWdata(a_MemWdata),
    .MemRdata(a_MemRdata)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .IReq(b_IReq), .IAddr(b_IAddr), .IGnt(b_IGnt), .IValid(b_IValid), .IRdata(b_IRdata),
    .DReq(b_DReq), .DWr(b_DWr), .DAddr(b_DAddr), .DWdata(b_DWdata),
    .DGnt(b_DGnt), .DValid(b_DValid), .DRdata(b_DRdata),
    .MemEn(b_MemEn), .MemWr(b_MemWr), .MemAddr(b_MemAddr), .MemWdata(b_MemWdata),
    .MemRdata(b_MemRdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk1 ({tag, ".IGnt"},    a_IGnt,    1'b0);
    chk1 ({tag, ".IValid"},  a_IValid,  1'b0);
    chk1 ({tag, ".DGnt"},    a_DGnt,    1'b0);
    chk1 ({tag, ".DValid"},  a_DValid,  1'b0);
    chk1 ({tag, ".MemEn"},   a_MemEn,   1'b0);
    chk1 ({tag, ".MemWr"},   a_MemWr,   1'b0);
    chk64({tag, ".MemAddr"}, a_MemAddr, 64'h0);
    chk64({tag, ".MemWdata"},a_MemWdata,64'h0);
    chk64({tag, ".IRdata"},  a_IRdata,  64'h0);
    chk64({tag, ".DRdata"},  a_DRdata,  64'h0);
  endtask

  logic [9:0] starve_pat;
  logic       exp_d;

  initial begin
    a_IReq = 0; a_DReq = 0; a_DWr = 0;
    a_IAddr = '0; a_DAddr = '0; a_DWdata = '0; a_MemRdata = '0;
    b_IReq = 0; b_DReq = 0; b_DWr = 0;
    b_IAddr = '0; b_DAddr = '0; b_DWdata = '0; b_MemRdata = '0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #2;
    chk_a_zero("por");
    chk1("por.b.DGnt", b_DGnt, 1'b0);
    repeat (2) tick();
    Reset = 1'b1;
    tick();

    // Fetch only, IAddr=0x4
    a_IReq = 1; a_IAddr = 64'h4; a_MemRdata = 64'hAAAA;
    chk1("t2.T.IGnt", a_IGnt, 1'b0);
    tick();
    chk1 ("t2.T1.IGnt",    a_IGnt,    1'b1);
    chk1 ("t2.T1.DGnt",    a_DGnt,    1'b0);
    chk1 ("t2.T1.MemEn",   a_MemEn,   1'b1);
    chk1 ("t2.T1.MemWr",   a_MemWr,   1'b0);
    chk64("t2.T1.MemAddr", a_MemAddr, 64'h4);
    a_IReq = 0;
    tick();
    a_MemRdata = 64'h00500093;
    chk1 ("t2.T2.IGnt",    a_IGnt,    1'b0);
    chk1 ("t2.T2.MemEn",   a_MemEn,   1'b0);
    chk1 ("t2.T2.IValid",  a_IValid,  1'b0);
    chk64("t2.T2.MemAddr", a_MemAddr, 64'h4);
    tick();
    a_MemRdata = 64'h1111;
    chk1 ("t2.T3.IValid",  a_IValid,  1'b1);
    chk1 ("t2.T3.DValid",  a_DValid,  1'b0);
    chk64("t2.T3.IRdata",  a_IRdata,  64'h00500093);
    chk64("t2.T3.DRdata",  a_DRdata,  64'h0);
    tick();
    chk1 ("t2.T4.IValid",  a_IValid,  1'b0);

    // D write 0xDEADBEEF to 0x20
    a_DReq = 1; a_DWr = 1; a_DAddr = 64'h20; a_DWdata = 64'hDEADBEEF;
    tick();
    chk1 ("t3.T1.DGnt",     a_DGnt,     1'b1);
    chk1 ("t3.T1.IGnt",     a_IGnt,     1'b0);
    chk1 ("t3.T1.MemEn",    a_MemEn,    1'b1);
    chk1 ("t3.T1.MemWr",    a_MemWr,    1'b1);
    chk64("t3.T1.MemAddr",  a_MemAddr,  64'h20);
    chk64("t3.T1.MemWdata", a_MemWdata, 64'hDEADBEEF);
    a_DReq = 0; a_DWr = 0;
    tick();
    a_MemRdata = 64'h5555;
    chk1 ("t3.T2.MemEn",    a_MemEn,    1'b0);
    chk1 ("t3.T2.MemWr",    a_MemWr,    1'b0);
    chk1 ("t3.T2.DGnt",     a_DGnt,     1'b0);
    chk64("t3.T2.MemWdata", a_MemWdata, 64'hDEADBEEF);
    tick();
    chk1 ("t3.T3.DValid",   a_DValid,   1'b1);
    chk64("t3.T3.DRdata",   a_DRdata,   64'h0);
    chk64("t3.T3.IRdata",   a_IRdata,   64'h00500093);
    tick();

    // Simultaneous I and D requests: D first, then I
    a_IReq = 1; a_IAddr = 64'h40;
    a_DReq = 1; a_DWr = 0; a_DAddr = 64'h80;
    tick();
    chk1 ("t4.T1.DGnt",    a_DGnt,    1'b1);
    chk1 ("t4.T1.IGnt",    a_IGnt,    1'b0);
    chk64("t4.T1.MemAddr", a_MemAddr, 64'h80);
    a_DReq = 0;
    tick();
    a_MemRdata = 64'h12345678;
    tick();
    a_MemRdata = 64'h0;
    chk1 ("t4.T3.DValid",  a_DValid,  1'b1);
    chk1 ("t4.T3.IGnt",    a_IGnt,    1'b0);
    chk64("t4.T3.DRdata",  a_DRdata,  64'h12345678);
    tick();
    chk1 ("t4.T4.IGnt",    a_IGnt,    1'b0);
    tick();
    chk1 ("t4.T5.IGnt",    a_IGnt,    1'b1);
    chk1 ("t4.T5.DGnt",    a_DGnt,    1'b0);
    chk64("t4.T5.MemAddr", a_MemAddr, 64'h40);
    a_IReq = 0;
    tick();
    a_MemRdata = 64'h9ABC;
    tick();
    chk1 ("t4.T7.IValid",  a_IValid,  1'b1);
    chk64("t4.T7.IRdata",  a_IRdata,  64'h9ABC);
    tick();

    // Starvation: both held; bit g set = D expected to win grant g
    starve_pat = 10'b0111101111;
    a_IReq = 1; a_IAddr = 64'h100;
    a_DReq = 1; a_DWr = 0; a_DAddr = 64'h200;
    for (int g = 0; g < 10; g++) begin
      exp_d = starve_pat[g];
      tick();
      chk1($sformatf("t5.g%0d.DGnt", g), a_DGnt, exp_d);
      chk1($sformatf("t5.g%0d.IGnt", g), a_IGnt, !exp_d);
      tick();
      a_MemRdata = 64'(g + 32'h300);
      tick();
      chk1($sformatf("t5.g%0d.DValid", g), a_DValid, exp_d);
      chk1($sformatf("t5.g%0d.IValid", g), a_IValid, !exp_d);
      tick();
    end
    a_IReq = 0; a_DReq = 0;
    chk64("t5.IRdata", a_IRdata, 64'h309);
    chk64("t5.DRdata", a_DRdata, 64'h308);
    tick();

    // Reset during WAIT of a D read
    a_DReq = 1; a_DWr = 0; a_DAddr = 64'h100;
    tick();
    chk1("t1.T1.DGnt", a_DGnt, 1'b1);
    a_DReq = 0;
    tick();
    a_MemRdata = 64'hBAD0;
    #2 Reset = 1'b0;
    #1;
    chk_a_zero("t1.async");
    tick();
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("t1.post%0d.DValid", k), a_DValid, 1'b0);
      tick();
    end
    a_IReq = 1; a_IAddr = 64'h10;
    tick();
    chk1 ("t1.T1.IGnt",    a_IGnt,    1'b1);
    chk64("t1.T1.MemAddr", a_MemAddr, 64'h10);
    a_IReq = 0;
    tick();
    a_MemRdata = 64'h77;
    chk1 ("t1.T2.IValid",  a_IValid,  1'b0);
    tick();
    chk1 ("t1.T3.IValid",  a_IValid,  1'b1);
    chk1 ("t1.T3.DValid",  a_DValid,  1'b0);
    chk64("t1.T3.IRdata",  a_IRdata,  64'h77);
    chk64("t1.T3.DRdata",  a_DRdata,  64'h0);
    tick();

    // MEM_LAT=3: D read at 0x8
    b_DReq = 1; b_DWr = 0; b_DAddr = 64'h8; b_MemRdata = 64'hA0;
    tick();
    chk1 ("t6.T1.DGnt",    b_DGnt,    1'b1);
    chk1 ("t6.T1.MemEn",   b_MemEn,   1'b1);
    chk64("t6.T1.MemAddr", b_MemAddr, 64'h8);
    b_DReq = 0;
    tick();
    b_MemRdata = 64'hA1;
    chk1("t6.T2.DValid", b_DValid, 1'b0);
    tick();
    b_MemRdata = 64'hA2;
    chk1("t6.T3.DValid", b_DValid, 1'b0);
    tick();
    b_MemRdata = 64'hA3;
    chk1("t6.T4.DValid", b_DValid, 1'b0);
    tick();
    b_MemRdata = 64'hA4;
    chk1 ("t6.T5.DValid", b_DValid, 1'b1);
    chk64("t6.T5.DRdata", b_DRdata, 64'hA3);
    tick();
    chk1 ("t6.T6.DValid", b_DValid, 1'b0);
    chk64("t6.T6.DRdata", b_DRdata, 64'hA3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
